adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 15 +
 rtl/adder_arbiter_brent_kung.sv | 49 ++++
 rtl/adder_arbiter.sv | 149 ++++++++++++++
 tb/tb_adder_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared constants and helpers for the adder arbiter and its adder.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: DW (datapath width), CNTW (op counter width), rr_next (round-robin successor).
package adder_arb_pkg;

  localparam int DW   = 32;
  localparam int CNTW = 16;

  // Successor of idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_brent_kung.sv
// 32-bit Brent-Kung parallel-prefix adder: {cout,sum} = a + b + cin.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a, b (DW-bit operands), cin (carry-in), sum (DW-bit), cout (carry-out).
module Brent_kung_32bitt
  import adder_arb_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout
);

  localparam int AW = $clog2(DW);

  logic [DW-1:0] p0;
  logic [DW-1:0] gv;
  logic [DW-1:0] pv;

  always_comb begin
    int j;
    j  = 0;
    p0 = a ^ b;
    gv = a & b;
    pv = p0;
    // Fold cin into bit 0 so every prefix from bit 0 already includes it.
    gv[0] = gv[0] | (p0[0] & cin);
    // Up-sweep: build power-of-two spans.
    for (int d = 1; d < DW; d = d * 2) begin
      for (int i = 2 * d - 1; i < DW; i = i + 2 * d) begin
        j = i - d;
        gv[i[AW-1:0]] = gv[i[AW-1:0]] | (pv[i[AW-1:0]] & gv[j[AW-1:0]]);
        pv[i[AW-1:0]] = pv[i[AW-1:0]] & pv[j[AW-1:0]];
      end
    end
    // Down-sweep: fill the remaining prefixes from bit 0.
    for (int d = DW / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < DW; i = i + 2 * d) begin
        j = i - d;
        gv[i[AW-1:0]] = gv[i[AW-1:0]] | (pv[i[AW-1:0]] & gv[j[AW-1:0]]);
      end
    end
  end

  assign sum  = p0 ^ {gv[DW-2:0], cin};
  assign cout = gv[DW-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder among NREQ requesters, result registered.
// Latency: 1 cycle from accepted request to res_valid.
// Backpressure: req_ready only while the result slot is empty or being drained (res_ready).
// Ports: req_valid/req_ready/req_a/req_b/req_cin per requester; res_valid/res_ready/res_id/
//        res_sum/res_cout result; op_count saturating accept count.
// Option: define ADDER_ARBITER_OVF_EN to add res_ovf (signed overflow of the result).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [IDW-1:0]     res_id,
  output logic [DW-1:0]      res_sum,
  output logic               res_cout,
  output logic [CNTW-1:0]    op_count
`ifdef ADDER_ARBITER_OVF_EN
  ,
  output logic               res_ovf
`endif
);

  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];
  logic [IDW-1:0]  gnt;
  logic            gnt_vld;
  logic            accept_ok;
  logic            xfer;
  logic [DW-1:0]   op_a, op_b, add_sum;
  logic            op_cin, add_cout;
  int              idx;

  logic            res_valid_q, res_valid_d;
  logic [DW-1:0]   res_sum_q, res_sum_d;
  logic            res_cout_q, res_cout_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[DW*i +: DW];
    assign b_arr[i] = req_b[DW*i +: DW];
  end

  // Grant depends only on req_valid and the pointer, never on operands.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = rr_next(int'(last_grant_q), NREQ);
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_vld && req_valid[idx[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[IDW-1:0];
      end
      idx = rr_next(idx, NREQ);
    end
  end

  assign accept_ok = !res_valid_q || res_ready;
  assign xfer      = gnt_vld && accept_ok;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end

  assign op_a   = a_arr[gnt];
  assign op_b   = b_arr[gnt];
  assign op_cin = req_cin[gnt];

  Brent_kung_32bitt u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_id_d     = res_id_q;
    op_count_d   = op_count_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      // A new accept wins over a same-edge handoff: slot stays full.
      res_valid_d  = 1'b1;
      res_sum_d    = add_sum;
      res_cout_d   = add_cout;
      res_id_d     = gnt;
      last_grant_d = gnt;
      if (op_count_q != {CNTW{1'b1}}) op_count_d = op_count_q + 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= '0;
      op_count_q   <= '0;
      // Pointing at the last index makes requester 0 the first searched.
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_id_q     <= res_id_d;
      op_count_q   <= op_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

`ifdef ADDER_ARBITER_OVF_EN
  logic res_ovf_q, res_ovf_d;

  always_comb begin
    res_ovf_d = res_ovf_q;
    if (xfer) res_ovf_d = (op_a[DW-1] == op_b[DW-1]) && (add_sum[DW-1] != op_a[DW-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_ovf_q <= 1'b0;
    else        res_ovf_q <= res_ovf_d;
  end

  assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, single request, carry, backpressure,
// asynchronous reset mid-flight and round-robin fairness.
// Outputs are sampled 1 time unit after the rising edge.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic [31:0]       res_sum;
  logic              res_cout;
  logic [15:0]       op_count;
`ifdef ADDER_ARBITER_OVF_EN
  logic              res_ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .op_count  (op_count)
`ifdef ADDER_ARBITER_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fair_a   [4] = '{32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000};
  logic [31:0] fair_b   [4] = '{32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040};
  logic        fair_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] fair_sum [4] = '{32'h0000_0011, 32'h0000_0121, 32'h0001_0030, 32'h0100_0041};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum",   res_sum,   0);
    chk("rst_res_cout",  res_cout,  0);
    chk("rst_res_id",    res_id,    0);
    chk("rst_op_count",  op_count,  0);
    chk("rst_req_ready", req_ready, 0);

    // Single requester 2
    rst_n = 1'b1;
    set_op(2, 32'h0000_1234, 32'h0000_5678, 1'b0);
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", req_ready, 4'b0100);
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_id",    res_id,    2);
    chk("single_sum",   res_sum,   32'h0000_68AC);
    chk("single_cout",  res_cout,  0);
    chk("single_cnt",   op_count,  1);
    req_valid = '0;
    #1;
    chk("idle_req_ready", req_ready, 0);
    tick();
    chk("handoff_no_xfer_valid", res_valid, 0);

    // Carry with cin on requester 3, then signed overflow vector on requester 0
    set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    req_valid = 4'b1000;
    #1;
    chk("carry_req_ready", req_ready, 4'b1000);
    tick();
    chk("carry_sum",  res_sum,  32'hFFFF_FFFF);
    chk("carry_cout", res_cout, 1);
    chk("carry_id",   res_id,   3);
`ifdef ADDER_ARBITER_OVF_EN
    chk("carry_ovf",  res_ovf,  0);
`endif
    set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    req_valid = 4'b0001;
    tick();
    chk("ovf_sum",  res_sum,  32'h8000_0000);
    chk("ovf_cout", res_cout, 0);
    chk("ovf_id",   res_id,   0);
    chk("ovf_cnt",  op_count, 3);
`ifdef ADDER_ARBITER_OVF_EN
    chk("ovf_flag", res_ovf,  1);
`endif
    req_valid = '0;
    tick();
    chk("idle2_valid", res_valid, 0);

    // Backpressure on requester 1
    res_ready = 1'b0;
    set_op(1, 32'h1111_1111, 32'h2222_2222, 1'b1);
    req_valid = 4'b0010;
    #1;
    chk("bp_first_ready", req_ready, 4'b0010);
    tick();
    chk("bp_first_sum", res_sum,  32'h3333_3334);
    chk("bp_first_cnt", op_count, 4);
    set_op(1, 32'h0000_0005, 32'h0000_0006, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_ready", req_ready, 0);
      tick();
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_sum",   res_sum,   32'h3333_3334);
      chk("bp_hold_id",    res_id,    1);
      chk("bp_hold_cnt",   op_count,  4);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b0010);
    tick();
    chk("bp_new_valid", res_valid, 1);
    chk("bp_new_sum",   res_sum,   32'h0000_000B);
    chk("bp_new_id",    res_id,    1);
    chk("bp_new_cnt",   op_count,  5);

    // Asynchronous reset while a result is pending
    rst_n = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_cnt",   op_count,  0);
    chk("arst_sum",   res_sum,   0);
    tick();
    chk("arst_hold_valid", res_valid, 0);
    chk("arst_hold_cnt",   op_count,  0);
    req_valid = '0;
    rst_n = 1'b1;

    // Fairness: all valid, priority restarts at requester 0
    for (int i = 0; i < 4; i++) set_op(i, fair_a[i], fair_b[i], fair_c[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_req_ready", req_ready, 32'd1 << (k % 4));
      tick();
      chk("rr_valid", res_valid, 1);
      chk("rr_id",    res_id,    k % 4);
      chk("rr_sum",   res_sum,   fair_sum[k % 4]);
      chk("rr_cnt",   op_count,  k + 1);
    end
    chk("rr_final_cnt", op_count, 8);
    req_valid = '0;
    tick();
    chk("final_valid", res_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
